// File: rtl/spm_drv_pkg.sv
// Shared types and helpers for the spm serial driver.
package spm_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } state_t;

  localparam int unsigned MAX_PIPE_LAT = 3;

  // Counter must reach 2*width+lat-1; one spare code keeps the compare simple.
  function automatic int unsigned cnt_w(input int unsigned width, input int unsigned lat);
    return $clog2(2 * width + lat + 1);
  endfunction

endpackage

// File: rtl/spm_sipo.sv
// Serial-in/parallel-out capture register for the spm product stream.
// Bits enter at the MSB, so the first captured bit ends at bit 0.
// Ports: clk, rst (sync, active-high), en (shift window), bit_in (serial bit),
//        cnt (shift-cycle index), q (captured word).
module spm_sipo
  import spm_drv_pkg::*;
#(
  parameter int unsigned WIDTH2 = 64,
  parameter int unsigned SKIP   = 1,
  localparam int unsigned CW    = cnt_w(WIDTH2 / 2, SKIP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bit_in,
  input  logic [CW-1:0]     cnt,
  output logic [WIDTH2-1:0] q
);

  // The first SKIP shift cycles cover the spm pipeline latency and carry no product bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en && (cnt >= CW'(SKIP))) begin
      q <= {bit_in, q[WIDTH2-1:1]};
    end
  end

endmodule

// File: rtl/spm_serial_driver.sv
// Host-side driver for one serial-parallel multiplier (spm).
// Accepts (x, y), holds x parallel on the spm, shifts y in LSB-first with
// zero padding, and reassembles the serial product into a 2*WIDTH word.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_x/in_y operand
//        handshake; spm_rst/spm_x/spm_y/spm_p spm link; out_valid/out_ready/
//        out_prod product handshake; busy (not IDLE).
module spm_serial_driver
  import spm_drv_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PIPE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  output logic               spm_rst,
  output logic [WIDTH-1:0]   spm_x,
  output logic               spm_y,
  input  logic               spm_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  localparam int unsigned W2   = 2 * WIDTH;
  localparam int unsigned CW   = cnt_w(WIDTH, PIPE_LAT);
  localparam int unsigned LAST = W2 + PIPE_LAT - 1;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_sh;
  logic [W2-1:0]   prod_sh;
  logic [W2-1:0]   prod_q;
  logic            last;

  assign last     = (cnt == CW'(LAST));
  assign spm_x    = x_q;
  assign out_prod = prod_q;
  assign spm_y    = ((state == SHIFT) && (cnt < CW'(WIDTH))) ? y_sh[0] : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    spm_rst   = rst;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        spm_rst   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      x_q    <= '0;
      y_sh   <= '0;
      prod_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q  <= in_x;
            y_sh <= in_y;
            cnt  <= '0;
          end
        end
        CLEAR: cnt <= '0;
        SHIFT: begin
          cnt  <= cnt + CW'(1);
          y_sh <= y_sh >> 1;
          // The capture register shifts on this same edge, so take its next value here.
          if (last) begin
            prod_q <= W2'({spm_p, prod_sh} >> 1);
          end
        end
        default: ;
      endcase
    end
  end

  spm_sipo #(
    .WIDTH2(W2),
    .SKIP  (PIPE_LAT)
  ) u_sipo (
    .clk   (clk),
    .rst   (rst),
    .en    (state == SHIFT),
    .bit_in(spm_p),
    .cnt   (cnt),
    .q     (prod_sh)
  );

endmodule

// File: tb/tb_spm_serial_driver.sv
module tb_spm_serial_driver;

  localparam int W      = 4;
  localparam int LAT    = 1;
  localparam int DONE_K = 2 * W + LAT + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_x;
  logic [3:0] in_y;
  logic       spm_rst;
  logic [3:0] spm_x;
  logic       spm_y;
  logic       spm_p;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_prod;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spm_serial_driver #(
    .WIDTH   (W),
    .PIPE_LAT(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .spm_rst  (spm_rst),
    .spm_x    (spm_x),
    .spm_y    (spm_y),
    .spm_p    (spm_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod (out_prod),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural spm: product bit n depends only on y bits 0..n received since its clear.
  int          s_n = 0;
  logic [63:0] s_y = '0;
  always @(posedge clk) begin
    if (spm_rst) begin
      s_n = 0;
      s_y = '0;
      spm_p <= 1'b0;
    end else begin
      s_y = s_y | (64'(spm_y) << s_n);
      spm_p <= 1'(((64'(spm_x) * s_y) >> s_n));
      if (s_n < 40) s_n++;
    end
  end

  // Transaction model: m_k counts cycles since the accept edge.
  bit         m_active = 0;
  int         m_k      = 0;
  logic [3:0] m_x = '0, m_y = '0, m_lx = '0;
  logic [7:0] m_prod = '0;
  int         cyc = 0;
  int         accepts[$];
  logic [7:0] prods[$];

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0;
      m_k      = 0;
      m_lx     = '0;
      m_prod   = '0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active = 1;
        m_k      = 1;
        m_x      = in_x;
        m_y      = in_y;
        m_lx     = in_x;
        accepts.push_back(cyc);
      end
    end else if (m_k == DONE_K) begin
      if (out_ready) begin
        m_active = 0;
        prods.push_back(out_prod);
      end
    end else begin
      m_k++;
      if (m_k == DONE_K) m_prod = 8'(m_x) * 8'(m_y);
    end
    cyc++;
  end

  logic [7:0] ybits = '0;
  always @(negedge clk) begin
    logic ey;
    if (rst) begin
      chk("spm_rst_during_rst", spm_rst, 1'b1);
    end else begin
      ey = 1'b0;
      if (m_active && m_k >= 2 && (m_k - 2) < W) ey = m_y[m_k-2];
      if (m_active && m_k >= 2 && m_k <= 2 * W + 1) ybits[m_k-2] = spm_y;
      chk("in_ready", in_ready, !m_active);
      chk("busy", busy, m_active);
      chk("spm_rst", spm_rst, m_active && m_k == 1);
      chk("spm_y", spm_y, ey);
      chk("out_valid", out_valid, m_active && m_k == DONE_K);
      chk("out_prod", out_prod, m_prod);
      chk("spm_x", spm_x, m_lx);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y, input bit keep);
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !in_ready; i++) step();
    chk("send_ready", in_ready, 1'b1);
    step();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int np;
    int a;
    logic [3:0] rx, ry;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_prod", out_prod, 8'h00);
    chk("rst_spm_x", spm_x, 4'h0);
    chk("rst_spm_y", spm_y, 1'b0);
    chk("rst_spm_rst", spm_rst, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // x=5, y=3
    send(4'd5, 4'd3, 0);
    wait_valid(n);
    chk("t1_latency", n, 10);
    chk("t1_prod", out_prod, 8'h0F);
    chk("t1_ybits", ybits, 8'h03);
    step();

    // x=15, y=15 with a stray in_valid pulse while busy
    np = prods.size();
    send(4'd15, 4'd15, 0);
    repeat (3) step();
    in_x = 4'd2; in_y = 4'd2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(n);
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_prod", out_prod, 8'hE1);
    repeat (15) step();
    chk("t2_one_product", prods.size() - np, 1);

    // x=0, y=11
    send(4'd0, 4'd11, 0);
    chk("t3_clear_on", spm_rst, 1'b1);
    step();
    chk("t3_clear_off", spm_rst, 1'b0);
    wait_valid(n);
    chk("t3_prod", out_prod, 8'h00);
    chk("t3_ybits", ybits, 8'h0B);
    step();

    // Backpressure on the product
    out_ready = 1'b0;
    send(4'd9, 4'd7, 0);
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_prod", out_prod, 8'h3F);
      chk("t4_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    chk("t4_released", out_valid, 1'b0);
    chk("t4_ready_back", in_ready, 1'b1);

    // Reset during SHIFT cnt=3
    np = prods.size();
    send(4'd13, 4'd9, 0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t5_ready_after_rst", in_ready, 1'b1);
    chk("t5_no_valid", out_valid, 1'b0);
    send(4'd6, 4'd6, 0);
    wait_valid(n);
    chk("t5_prod", out_prod, 8'h24);
    step();
    chk("t5_count", prods.size() - np, 1);

    // Back-to-back operand pairs
    out_ready = 1'b1;
    send(4'd5, 4'd3, 1);
    send(4'd15, 4'd15, 0);
    wait_valid(n);
    step();
    a = accepts.size();
    chk("t6_gap", accepts[a-1] - accepts[a-2], 12);
    chk("t6_prod0", prods[prods.size()-2], 8'h0F);
    chk("t6_prod1", prods[prods.size()-1], 8'hE1);

    // Randomised operands and consumer backpressure
    for (int t = 0; t < 25; t++) begin
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      send(rx, ry, 0);
      n = 0;
      while (m_active && n < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      chk("rnd_done", m_active, 1'b0);
      chk("rnd_prod", prods[prods.size()-1], 8'(rx) * 8'(ry));
      repeat ($urandom_range(0, 2)) step();
    end

    out_ready = 1'b1;
    repeat (5) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spm_serial_driver.md
Name: spm_serial_driver

Overview:
- Host-side companion to the serial-parallel multiplier (spm); drives the multiplier's serial input side and reassembles its serial output.
- Accepts a parallel operand pair (x, y) over a valid/ready handshake.
- Holds x parallel on the spm, shifts y in LSB-first and zero-pads, then collects the serial product bits into a 2*WIDTH word.
- Presents the word on an output valid/ready handshake. Sits between a bus-facing front end and one spm instance.

Parameters:
- WIDTH, 32: operand width; must match the spm instance; product is 2*WIDTH.
- PIPE_LAT, 1: cycles from presenting serial y bit k on spm_y to product bit k appearing on spm_p; range 0..3.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_x  in  WIDTH  multiplicand (parallel to spm).
- in_y  in  WIDTH  multiplier (serialised to spm).
- spm_rst  out  1  synchronous clear for the spm carry-save state.
- spm_x  out  WIDTH  parallel operand to spm.
- spm_y  out  1  serial operand bit to spm.
- spm_p  in  1  serial product bit from spm.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_prod  out  2*WIDTH  unsigned product x*y.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; counters, operand and product registers cleared.
  - out_valid=0, out_prod=0, spm_x=0, spm_y=0.
  - spm_rst=1 combinationally for as long as rst is high.
  - in_ready=1 from the first cycle after rst deasserts.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready at edge T0: latch x and y, go to CLEAR.
  - CLEAR: one cycle, spm_rst=1, in_ready=0. Go to SHIFT with cnt=0.
  - SHIFT: runs 2*WIDTH+PIPE_LAT cycles; cnt increments every cycle.
    - spm_y = y_sh[0] for cnt<WIDTH, else 0. y_sh shifts right each SHIFT cycle.
    - For cnt>=PIPE_LAT: prod_sh = {spm_p, prod_sh[2W-1:1]}, i.e. shifts in at MSB, so the first captured bit ends at bit 0.
    - At cnt=2*WIDTH+PIPE_LAT-1: go to DONE, and out_prod takes the final prod_sh value.
  - DONE: out_valid=1, with out_prod stable until out_valid && out_ready at an edge, then go to IDLE.
- Timing:
  - out_valid is high in cycle T0+2*WIDTH+PIPE_LAT+2. For WIDTH=4, PIPE_LAT=1, that is T0+11.
  - Throughput: one product per 2*WIDTH+PIPE_LAT+3 cycles minimum; the IDLE cycle is mandatory and there is no overlap.
- spm_x holds the latched x through CLEAR, SHIFT and DONE; returns to 0 only on reset.
- in_ready is a combinational decode of state==IDLE. in_valid is ignored outside IDLE, and inputs are not sampled after the accept edge.
- out_valid does not depend combinationally on out_ready. With out_ready held low, DONE persists indefinitely and out_prod does not change.
- Reset mid-operation (any state): abort immediately, no out_valid pulse, state=IDLE. The next operation re-runs CLEAR, so no stale spm state survives.
- Arithmetic: unsigned only. The product always fits 2*WIDTH bits; no overflow or truncation.
- Counter width: $clog2(2*WIDTH+PIPE_LAT+1).

Decomposition:
- Shared package spm_drv_pkg:
  - state enum {IDLE, CLEAR, SHIFT, DONE};
  - function cnt_w(width, lat) returning the counter width;
  - localparam MAX_PIPE_LAT=3.
- One sub-module, spm_sipo: serial-in/parallel-out capture register.
  - Parameters WIDTH2, SKIP.
  - Ports clk, rst, en, bit_in, cnt, q.
  - Lets the capture alignment be verified in isolation.
- The FSM and the y shifter stay in spm_serial_driver.

Test Plan (WIDTH=4, PIPE_LAT=1, bench contains a behavioural spm with 1-cycle latency):
- x=5, y=3 -> spm_y sequence 1,1,0,0,0,0,0,0; out_valid at T0+11; out_prod=0x0F.
- x=15, y=15 -> out_prod=0xE1; a one-cycle in_valid pulse while busy is ignored, and exactly one product is produced.
- x=0, y=11 -> out_prod=0x00; spm_y sequence 1,1,0,1,0,0,0,0; spm_rst high exactly one cycle after accept.
- Hold out_ready=0 for 20 cycles after x=9, y=7 -> out_valid stays 1 and out_prod=0x3F stable; in_ready=0 until the handshake plus 1 cycle.
- rst asserted at SHIFT cnt=3 for one cycle -> no out_valid, in_ready=1 next cycle; following x=6, y=6 gives 0x24.
- Back-to-back operand pairs with out_ready=1 -> products 0x0F, 0xE1 in order; accepts spaced exactly 12 cycles apart.
